fat_sector_chain_reader: RTL and testbench

- Read-side counterpart to the FAT sector constructor. Reads one 128-entry FAT32 sector from the sector buffer RAM and decodes the stored entry format.
- Optionally counts free entries in the sector, then follows a cluster chain from a given start cluster until the chain ends, leaves the sector, or is found corrupt.
- Sits between the sector buffer and the file-append controller, which needs the chain tail and the next-sector hop.

---
 rtl/fat_pkg.sv | 36 +++
 rtl/fat_entry_decode.sv | 24 ++
 rtl/fat_sector_chain_reader.sv | 198 +++++++++++++++++++
 tb/tb_fat_sector_chain_reader.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fat_pkg.sv
// Shared FAT32 definitions: result codes, entry constants, reader state encoding
// and the stored-word decode (each byte is kept nibble-swapped in the sector buffer).
package fat_pkg;

   localparam int          FAT_ENTRIES  = 128;
   localparam logic [31:0] FAT_EOF_MIN  = 32'h0FFF_FFF8;
   localparam logic [31:0] FAT_BAD      = 32'h0FFF_FFF7;
   localparam logic [31:0] FAT_EOF_WORD = 32'hf0ff_ffff;

   typedef enum logic [2:0] {
      RK_EOF   = 3'd0,
      RK_EXIT  = 3'd1,
      RK_BAD   = 3'd2,
      RK_FREE  = 3'd3,
      RK_LOOP  = 3'd4,
      RK_RANGE = 3'd5
   } result_kind_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SCAN  = 3'd1,
      ST_DRAIN = 3'd2,
      ST_FREQ  = 3'd3,
      ST_FWAIT = 3'd4,
      ST_FIN   = 3'd5
   } state_e;

   // Swap nibbles within every byte, then keep the 28 significant entry bits.
   function automatic logic [27:0] fat_decode(input logic [31:0] word);
      logic [31:0] s;
      for (int b = 0; b < 4; b++)
         s[b*8 +: 8] = {word[b*8 +: 4], word[b*8+4 +: 4]};
      return s[27:0];
   endfunction

endpackage

// File: rtl/fat_entry_decode.sv
// Combinational FAT32 entry decoder: stored buffer word in, 28-bit value and
// FREE / BAD / EOF / link class flags out.
module fat_entry_decode
   import fat_pkg::*;
(
   input  logic [31:0] i_word,
   output logic [27:0] o_value,
   output logic        o_free,
   output logic        o_bad,
   output logic        o_eof,
   output logic        o_link
);

   logic [31:0] w_val32;

   assign o_value = fat_decode(i_word);
   assign w_val32 = {4'h0, o_value};

   assign o_free = (w_val32 == 32'd0);
   assign o_bad  = (w_val32 == FAT_BAD) || (w_val32 == 32'd1);
   assign o_eof  = (w_val32 >= FAT_EOF_MIN);
   assign o_link = !(o_free || o_bad || o_eof);

endmodule

// File: rtl/fat_sector_chain_reader.sv
// Reads one 128-entry FAT32 sector: optional free-entry scan (FAT_FREE_SCAN_EN),
// then follows a cluster chain until EOF, exit from the sector, corruption or a loop.
module fat_sector_chain_reader
   import fat_pkg::*;
#(
   parameter int ENTRIES = FAT_ENTRIES,
   parameter int ADDR_W  = 7
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [31:0]       i_sector_base_clust,
   input  logic [31:0]       i_chain_clust,
   output logic              o_rena_sr,
   output logic [ADDR_W-1:0] o_raddr_sr,
   input  logic [31:0]       i_output_sr,
   output logic              o_busy,
   output logic              o_done,
   output logic [2:0]        o_result_kind,
   output logic [31:0]       o_last_clust,
   output logic [31:0]       o_next_clust,
   output logic [7:0]        o_chain_len,
   output logic [7:0]        o_free_count
);

   state_e       r_state, w_state_nxt;
   logic [31:0]  r_base, r_cur, r_last, r_next;
   logic [2:0]   r_kind;
   logic [7:0]   r_len;
   logic         r_done;

   logic [27:0]  w_value;
   logic [31:0]  w_val32;
   logic         w_free, w_bad, w_eof, w_link;
   logic         w_accept, w_in_range, w_out_win, w_fw_end;
   logic [7:0]   w_len_inc;
   result_kind_e w_fw_kind;

   fat_entry_decode u_dec (
      .i_word  (i_output_sr),
      .o_value (w_value),
      .o_free  (w_free),
      .o_bad   (w_bad),
      .o_eof   (w_eof),
      .o_link  (w_link)
   );

   assign w_val32 = {4'h0, w_value};

   // The DONE cycle is already IDLE; a START landing there is deliberately dropped.
   assign w_accept   = (r_state == ST_IDLE) && i_start && !r_done;
   assign w_in_range = (i_chain_clust >= 32'd2) &&
                       (i_chain_clust >= i_sector_base_clust) &&
                       (i_chain_clust <= i_sector_base_clust + 32'(ENTRIES-1));
   assign w_out_win  = (w_val32 < r_base) || (w_val32 > r_base + 32'(ENTRIES-1));
   assign w_len_inc  = (r_len == 8'(ENTRIES)) ? r_len : r_len + 8'd1;

   always_comb begin
      w_fw_end  = 1'b1;
      w_fw_kind = RK_EOF;
      if (w_eof)                        w_fw_kind = RK_EOF;
      else if (w_bad)                   w_fw_kind = RK_BAD;
      else if (w_free)                  w_fw_kind = RK_FREE;
      else if (w_link && w_out_win)     w_fw_kind = RK_EXIT;
      else if (w_len_inc == 8'(ENTRIES)) w_fw_kind = RK_LOOP;
      else                              w_fw_end  = 1'b0;
   end

`ifdef FAT_FREE_SCAN_EN
   logic [ADDR_W-1:0] r_scan_addr;
   logic [ADDR_W-1:0] r_scan_idx;
   logic              r_scan_vld;
   logic [7:0]        r_free;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
`ifdef FAT_FREE_SCAN_EN
               w_state_nxt = w_in_range ? ST_SCAN : ST_FIN;
`else
               w_state_nxt = w_in_range ? ST_FREQ : ST_FIN;
`endif
            end
         end
`ifdef FAT_FREE_SCAN_EN
         ST_SCAN:  if (r_scan_addr == ADDR_W'(ENTRIES-1)) w_state_nxt = ST_DRAIN;
         ST_DRAIN: w_state_nxt = ST_FREQ;
`endif
         ST_FREQ:  w_state_nxt = ST_FWAIT;
         ST_FWAIT: w_state_nxt = w_fw_end ? ST_FIN : ST_FREQ;
         ST_FIN:   w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      o_rena_sr  = 1'b0;
      o_raddr_sr = '0;
      o_busy     = (r_state != ST_IDLE);
      case (r_state)
`ifdef FAT_FREE_SCAN_EN
         ST_SCAN: begin
            o_rena_sr  = 1'b1;
            o_raddr_sr = r_scan_addr;
         end
`endif
         ST_FREQ: begin
            o_rena_sr  = 1'b1;
            o_raddr_sr = ADDR_W'(r_cur - r_base);
         end
         default: ;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_base <= '0;
         r_cur  <= '0;
         r_last <= '0;
         r_next <= '0;
         r_kind <= '0;
         r_len  <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= (r_state == ST_FIN);
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_base <= i_sector_base_clust;
                  r_cur  <= i_chain_clust;
                  r_len  <= '0;
                  if (!w_in_range) begin
                     r_kind <= RK_RANGE;
                     r_last <= i_chain_clust;
                     r_next <= '0;
                  end
               end
            end
            ST_FWAIT: begin
               r_last <= r_cur;
               r_next <= w_val32;
               r_len  <= w_len_inc;
               if (w_fw_end) r_kind <= w_fw_kind;
               else          r_cur  <= w_val32;
            end
            default: ;
         endcase
      end
   end

`ifdef FAT_FREE_SCAN_EN
   // Read data trails the address by one cycle, so the class is judged on the
   // delayed index; entries 0/1 of sector 0 are reserved and never counted.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_scan_addr <= '0;
         r_scan_idx  <= '0;
         r_scan_vld  <= 1'b0;
         r_free      <= '0;
      end else begin
         r_scan_vld <= (r_state == ST_SCAN);
         r_scan_idx <= r_scan_addr;
         if (w_accept) begin
            r_scan_addr <= '0;
            r_free      <= '0;
         end else if (r_state == ST_SCAN) begin
            r_scan_addr <= r_scan_addr + ADDR_W'(1);
         end
         if (r_scan_vld && w_free &&
             !((r_base == 32'd0) && (r_scan_idx < ADDR_W'(2))))
            r_free <= r_free + 8'd1;
      end
   end

   assign o_free_count = r_free;
`else
   assign o_free_count = 8'd0;
`endif

   assign o_done        = r_done;
   assign o_result_kind = r_kind;
   assign o_last_clust  = r_last;
   assign o_next_clust  = r_next;
   assign o_chain_len   = r_len;

endmodule

// File: tb/tb_fat_sector_chain_reader.sv
// Bench for fat_sector_chain_reader: table of chain scenarios with a scoreboard,
// plus hand sequences for START-while-busy, START-on-DONE and mid-run reset.
module tb_fat_sector_chain_reader;

`ifdef FAT_FREE_SCAN_EN
   localparam int SCAN_CYC = 129;
`else
   localparam int SCAN_CYC = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, start;
   logic [31:0] base, chain, rdata;
   logic        rena, busy, done;
   logic [6:0]  raddr;
   logic [2:0]  kind;
   logic [31:0] last, nxt;
   logic [7:0]  len, freec;

   logic [31:0] mem [0:127];

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int          setup;
      logic [31:0] base;
      logic [31:0] chain;
      logic [2:0]  kind;
      logic [31:0] last;
      logic [31:0] next;
      int          len;
      int          free;
   } vec_t;

   typedef struct {
      logic [2:0]  kind;
      logic [31:0] last;
      logic [31:0] next;
      int          len;
      int          free;
      int          lat;
   } exp_t;

   vec_t vecs [10];
   exp_t sb [$];

   fat_sector_chain_reader dut (
      .i_clk               (clk),
      .i_rst_n             (rst_n),
      .i_start             (start),
      .i_sector_base_clust (base),
      .i_chain_clust       (chain),
      .o_rena_sr           (rena),
      .o_raddr_sr          (raddr),
      .i_output_sr         (rdata),
      .o_busy              (busy),
      .o_done              (done),
      .o_result_kind       (kind),
      .o_last_clust        (last),
      .o_next_clust        (nxt),
      .o_chain_len         (len),
      .o_free_count        (freec)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rena) rdata <= mem[raddr];

   function automatic logic [31:0] enc(input logic [31:0] v);
      return ((v & 32'h0F0F0F0F) << 4) | ((v >> 4) & 32'h0F0F0F0F);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic setup(input int id);
      for (int i = 0; i < 128; i++) mem[i] = 32'hf0ffffff;
      case (id)
         0: begin mem[0] = 0; mem[1] = 0; mem[4] = enc(5); mem[5] = enc(6); end
         1: mem[72] = enc(300);
         2: begin mem[0] = 0; mem[1] = 0; for (int i = 20; i < 30; i++) mem[i] = 0; end
         3: begin mem[4] = enc(5); mem[5] = enc(32'h0FFFFFF7); end
         4: begin mem[4] = enc(5); mem[5] = 0; end
         5: begin mem[10] = enc(11); mem[11] = enc(10); end
         8: mem[4] = enc(1);
         9: begin mem[0] = 0; mem[44] = enc(301); mem[45] = 32'hf0ffff8f; end
         default: ;
      endcase
   endtask

   // mode 0: plain, 1: START pulse while busy, 2: START in the DONE cycle
   task automatic run_vec(input vec_t v, input int mode);
      exp_t e, g;
      int   lat;
      bit   seen;
      setup(v.setup);
      e.kind = v.kind; e.last = v.last; e.next = v.next; e.len = v.len;
`ifdef FAT_FREE_SCAN_EN
      e.free = v.free;
`else
      e.free = 0;
`endif
      e.lat = (v.kind == 3'd5) ? 2 : 2 + SCAN_CYC + 2 * v.len;
      sb.push_back(e);
      base = v.base; chain = v.chain; start = 1'b1;
      lat = 0; seen = 1'b0;
      while (!seen && lat < 2000) begin
         @(posedge clk); #1;
         lat++;
         start = (mode == 1 && lat == 3);
         if (mode == 1 && lat == 3) chain = 32'd1;
         seen = done;
      end
      chk("done_seen", 32'(seen), 32'd1);
      if (!seen) begin
         g = sb.pop_front();
         return;
      end
      if (mode == 2) begin start = 1'b1; chain = 32'd1; base = 32'd0; end
      @(posedge clk); #1;
      start = 1'b0;
      chk("done_pulse_width", 32'(done), 32'd0);
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("rena_idle", 32'(rena), 32'd0);
      g = sb.pop_front();
      chk("result_kind", 32'(kind), 32'(g.kind));
      chk("last_clust", last, g.last);
      chk("next_clust", nxt, g.next);
      chk("chain_len", 32'(len), 32'(g.len));
      chk("free_count", 32'(freec), 32'(g.free));
      chk("latency", 32'(lat), 32'(g.lat));
   endtask

   initial begin
      int dcnt;
      vecs[0] = '{0, 32'd0,   32'd4,   3'd0, 32'd6,   32'h0FFFFFFF, 3,   0};
      vecs[1] = '{1, 32'd128, 32'd200, 3'd1, 32'd200, 32'd300,      1,   0};
      vecs[2] = '{2, 32'd0,   32'd2,   3'd0, 32'd2,   32'h0FFFFFFF, 1,   10};
      vecs[3] = '{3, 32'd0,   32'd4,   3'd2, 32'd5,   32'h0FFFFFF7, 2,   0};
      vecs[4] = '{4, 32'd0,   32'd4,   3'd3, 32'd5,   32'd0,        2,   1};
      vecs[5] = '{5, 32'd0,   32'd10,  3'd4, 32'd11,  32'd10,       128, 0};
      vecs[6] = '{6, 32'd0,   32'd1,   3'd5, 32'd1,   32'd0,        0,   0};
      vecs[7] = '{7, 32'd128, 32'd256, 3'd5, 32'd256, 32'd0,        0,   0};
      vecs[8] = '{8, 32'd0,   32'd4,   3'd2, 32'd4,   32'd1,        1,   0};
      vecs[9] = '{9, 32'd256, 32'd300, 3'd0, 32'd301, 32'h0FFFFFF8, 2,   1};

      rst_n = 1'b0; start = 1'b0; base = '0; chain = '0;
      setup(6);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rena", 32'(rena), 32'd0);
      chk("rst_kind", 32'(kind), 32'd0);
      chk("rst_len",  32'(len),  32'd0);
      chk("rst_free", 32'(freec), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) run_vec(vecs[i], 0);
      run_vec(vecs[0], 1);
      run_vec(vecs[2], 2);

      // Reset in the middle of following the looping chain
      setup(5); base = 32'd0; chain = 32'd10; start = 1'b1;
      repeat (SCAN_CYC + 10) begin @(posedge clk); #1; start = 1'b0; end
      chk("busy_mid_follow", 32'(busy), 32'd1);
      rst_n = 1'b0; #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_rena", 32'(rena), 32'd0);
      chk("abort_kind", 32'(kind), 32'd0);
      chk("abort_last", last, 32'd0);
      chk("abort_next", nxt, 32'd0);
      chk("abort_len",  32'(len), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      dcnt = 0;
      repeat (400) begin @(posedge clk); #1; if (done) dcnt++; end
      chk("no_done_after_abort", 32'(dcnt), 32'd0);
      chk("idle_after_abort", 32'(busy), 32'd0);

      run_vec(vecs[1], 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
